// File: rtl/sync_fifo_flags_pkg.sv
// Shared helpers for sync_fifo_flags: address-width derivation and parameter legality.
package sync_fifo_flags_pkg;

  // Pointer width for a given depth; at least one bit so tiny FIFOs still elaborate.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // True when v is a power of two of at least 2.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Depth must let pointers wrap naturally, and both thresholds must be reachable counts.
  function automatic bit params_legal(input int depth, input int af_level, input int ae_level);
    return is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_strobe_gen.sv
// Turns an access enable into a one-cycle request (edge mode) or passes it through (level mode).
module strobe_gen #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic req
);

  logic en_d;

  // Remember last cycle's enable; resetting to 1 stops an enable held through reset from firing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) en_d <= 1'b1;
    else          en_d <= en;
  end

  assign req = en & (EDGE_MODE ? ~en_d : 1'b1);

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with strobe modes, threshold flags,
// synchronous flush, sticky error flags and read/write pass-through when full.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit EDGE_MODE  = 1'b1,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    clear_err,
  input  logic                    write_en,
  input  logic                    read_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_illegal_params
    $error("sync_fifo_flags: illegal parameters DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           DEPTH, AF_LEVEL, AE_LEVEL);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;

  logic wr_req;
  logic rd_req;
  logic rd_ok;
  logic wr_ok;
  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic unf_set;

  strobe_gen #(.EDGE_MODE(EDGE_MODE)) u_wr_strobe (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (write_en),
    .req     (wr_req)
  );

  strobe_gen #(.EDGE_MODE(EDGE_MODE)) u_rd_strobe (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (read_en),
    .req     (rd_req)
  );

  // A read frees a slot in the same cycle, so a write into a full FIFO is legal alongside it.
  // Flush swallows both requests and keeps them from raising error flags.
  always_comb begin
    rd_ok   = rd_req & ~empty;
    wr_ok   = wr_req & (~full | rd_ok);
    rd_acc  = rd_ok & ~flush;
    wr_acc  = wr_ok & ~flush;
    ovf_set = wr_req & ~wr_ok & ~flush;
    unf_set = rd_req & empty & ~flush;
  end

  // Storage has no reset; only accepted writes touch it.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers and occupancy; flush wins over any accepted access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new offence in the same cycle beats clear_err.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (unf_set)        underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

  assign data_out     = mem[rd_ptr];
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a level-mode and an edge-mode instance checked against a queue model.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic flush = 1'b0;
  logic clear_err = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic we0 = 1'b0, re0 = 1'b0, we1 = 1'b0, re1 = 1'b0;
  logic [7:0] dout0, dout1;
  logic [4:0] cnt0, cnt1;
  logic full0, empty0, af0, ae0, ovf0, unf0;
  logic full1, empty1, af1, ae1, ovf1, unf1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(DEPTH), .EDGE_MODE(1'b0), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut0 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clear_err(clear_err),
    .write_en(we0), .read_en(re0), .data_in(data_in), .data_out(dout0), .count(cnt0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(DEPTH), .EDGE_MODE(1'b1), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .clear_err(clear_err),
    .write_en(we1), .read_en(re1), .data_in(data_in), .data_out(dout1), .count(cnt1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1));

  // Reference model: a queue per instance plus sticky flags and enable history.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit m_ovf0, m_unf0, m_ovf1, m_unf1;
  bit m_wprev1 = 1'b1, m_rprev1 = 1'b1;

  function automatic void ref_rules(input int size, input bit wreq, input bit rreq,
                                    input bit fl, input bit clr, input bit old_ovf, input bit old_unf,
                                    output bit wacc, output bit racc, output bit new_ovf, output bit new_unf);
    racc    = !fl && rreq && (size > 0);
    wacc    = !fl && wreq && ((size < DEPTH) || racc);
    new_ovf = (!fl && wreq && !wacc) ? 1'b1 : (clr ? 1'b0 : old_ovf);
    new_unf = (!fl && rreq && size == 0) ? 1'b1 : (clr ? 1'b0 : old_unf);
  endfunction

  always @(posedge clock or negedge reset_n) begin : model0
    bit wa, ra, no, nu;
    if (!reset_n) begin
      q0.delete(); m_ovf0 = 1'b0; m_unf0 = 1'b0;
    end else begin
      ref_rules(q0.size(), we0, re0, flush, clear_err, m_ovf0, m_unf0, wa, ra, no, nu);
      m_ovf0 = no; m_unf0 = nu;
      if (flush) q0.delete();
      else begin
        if (ra) void'(q0.pop_front());
        if (wa) q0.push_back(data_in);
      end
    end
  end

  always @(posedge clock or negedge reset_n) begin : model1
    bit wa, ra, no, nu, wreq, rreq;
    if (!reset_n) begin
      q1.delete(); m_ovf1 = 1'b0; m_unf1 = 1'b0; m_wprev1 = 1'b1; m_rprev1 = 1'b1;
    end else begin
      wreq = we1 && !m_wprev1;
      rreq = re1 && !m_rprev1;
      m_wprev1 = we1; m_rprev1 = re1;
      ref_rules(q1.size(), wreq, rreq, flush, clear_err, m_ovf1, m_unf1, wa, ra, no, nu);
      m_ovf1 = no; m_unf1 = nu;
      if (flush) q1.delete();
      else begin
        if (ra) void'(q1.pop_front());
        if (wa) q1.push_back(data_in);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic applyStimulus_reset();
    we0 = 0; re0 = 0; we1 = 0; re1 = 0; flush = 0; clear_err = 0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    tick();
    n_cmp++; if ({cnt0, empty0, full0, ae0, af0, ovf0, unf0} !== {5'd0, 6'b101000}) begin
      n_fail++; $display("FAIL reset_flags0: got cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b want cnt=0 e=1 f=0 ae=1 af=0 o=0 u=0",
                         cnt0, empty0, full0, ae0, af0, ovf0, unf0); end
    n_cmp++; if ({cnt1, empty1, full1, ae1, af1, ovf1, unf1} !== {5'd0, 6'b101000}) begin
      n_fail++; $display("FAIL reset_flags1: got cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b want cnt=0 e=1 f=0 ae=1 af=0 o=0 u=0",
                         cnt1, empty1, full1, ae1, af1, ovf1, unf1); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      data_in = 8'(i); we0 = 1'b1;
      tick();
      n_cmp++; if (cnt0 !== 5'(i + 1)) begin
        n_fail++; $display("FAIL fill_count: got %0d want %0d", cnt0, i + 1); end
      n_cmp++; if (af0 !== (i + 1 >= AF)) begin
        n_fail++; $display("FAIL fill_almost_full at count %0d: got %b want %b", i + 1, af0, (i + 1 >= AF)); end
    end
    we0 = 1'b0;
    n_cmp++; if (full0 !== 1'b1) begin
      n_fail++; $display("FAIL fill_full: got %b want 1", full0); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (dout0 !== 8'(i)) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, dout0, 8'(i)); end
      re0 = 1'b1;
      tick();
    end
    re0 = 1'b0;
    n_cmp++; if (empty0 !== 1'b1 || cnt0 !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty: got empty=%b cnt=%0d want empty=1 cnt=0", empty0, cnt0); end
  endtask

  task automatic test_overflow_passthrough();
    for (int i = 0; i < DEPTH; i++) begin
      data_in = 8'(i); we0 = 1'b1; tick();
    end
    data_in = 8'hAA; tick();
    we0 = 1'b0;
    n_cmp++; if (ovf0 !== 1'b1 || cnt0 !== 5'd16 || dout0 !== 8'h00) begin
      n_fail++; $display("FAIL overflow: got ovf=%b cnt=%0d head=%h want ovf=1 cnt=16 head=00", ovf0, cnt0, dout0); end
    data_in = 8'hBB; we0 = 1'b1; re0 = 1'b1; tick();
    we0 = 1'b0; re0 = 1'b0;
    n_cmp++; if (cnt0 !== 5'd16 || dout0 !== 8'h01) begin
      n_fail++; $display("FAIL passthrough: got cnt=%0d head=%h want cnt=16 head=01", cnt0, dout0); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (dout0 !== ((i < 15) ? 8'(i + 1) : 8'hBB)) begin
        n_fail++; $display("FAIL passthrough_data[%0d]: got %h want %h", i, dout0, (i < 15) ? 8'(i + 1) : 8'hBB); end
      re0 = 1'b1; tick();
    end
    re0 = 1'b0;
    clear_err = 1'b1; tick(); clear_err = 1'b0;
  endtask

  task automatic test_underflow();
    data_in = 8'h55; we0 = 1'b1; re0 = 1'b1; tick();
    we0 = 1'b0; re0 = 1'b0;
    n_cmp++; if (unf0 !== 1'b1 || cnt0 !== 5'd1 || dout0 !== 8'h55) begin
      n_fail++; $display("FAIL underflow: got unf=%b cnt=%0d head=%h want unf=1 cnt=1 head=55", unf0, cnt0, dout0); end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    n_cmp++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      n_fail++; $display("FAIL clear_err: got ovf=%b unf=%b want 0 0", ovf0, unf0); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      data_in = 8'(k * 3 + 1); we0 = 1'b1; tick(); we0 = 1'b0;
      n_cmp++; if (dout0 !== 8'(k * 3 + 1)) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", k, dout0, 8'(k * 3 + 1)); end
      re0 = 1'b1; tick(); re0 = 1'b0;
    end
    n_cmp++; if (cnt0 !== 5'd0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: got cnt=%0d ovf=%b unf=%b want 0 0 0", cnt0, ovf0, unf0); end
  endtask

  task automatic test_edge_mode();
    applyStimulus_reset();
    we1 = 1'b1; repeat (5) tick(); we1 = 1'b0; tick();
    n_cmp++; if (cnt1 !== 5'd1) begin
      n_fail++; $display("FAIL edge_hold: got %0d want 1", cnt1); end
    we1 = 1'b1; reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (cnt1 !== 5'd0) begin
      n_fail++; $display("FAIL edge_through_reset: got %0d want 0", cnt1); end
    we1 = 1'b0; tick();
    for (int t = 0; t < 3; t++) begin
      data_in = 8'(8'h30 + t); we1 = 1'b1; tick(); we1 = 1'b0; tick();
    end
    n_cmp++; if (cnt1 !== 5'd3 || dout1 !== 8'h30) begin
      n_fail++; $display("FAIL edge_toggle: got cnt=%0d head=%h want cnt=3 head=30", cnt1, dout1); end
  endtask

  task automatic test_flush();
    applyStimulus_reset();
    for (int i = 0; i < 9; i++) begin
      data_in = 8'(i + 8'h40); we0 = 1'b1; tick();
    end
    n_cmp++; if (cnt0 !== 5'd9) begin
      n_fail++; $display("FAIL flush_prefill: got %0d want 9", cnt0); end
    flush = 1'b1; tick(); flush = 1'b0; we0 = 1'b0;
    n_cmp++; if (cnt0 !== 5'd0 || ovf0 !== 1'b0 || empty0 !== 1'b1) begin
      n_fail++; $display("FAIL flush: got cnt=%0d ovf=%b empty=%b want 0 0 1", cnt0, ovf0, empty0); end
  endtask

  task automatic test_async_reset();
    we0 = 1'b1; data_in = 8'h77; repeat (3) tick();
    we1 = 1'b1; tick(); we1 = 1'b0; tick();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({cnt0, empty0, full0, ae0, af0, ovf0, unf0} !== {5'd0, 6'b101000}) begin
      n_fail++; $display("FAIL async_reset0: got cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b want 0 1 0 1 0 0 0",
                         cnt0, empty0, full0, ae0, af0, ovf0, unf0); end
    n_cmp++; if (cnt1 !== 5'd0 || empty1 !== 1'b1) begin
      n_fail++; $display("FAIL async_reset1: got cnt=%0d empty=%b want 0 1", cnt1, empty1); end
    we0 = 1'b0;
    tick(); reset_n = 1'b1; tick();
  endtask

  task automatic test_random();
    applyStimulus_reset();
    for (int c = 0; c < 800; c++) begin
      n_cmp++; if (cnt0 !== 5'(q0.size()) || empty0 !== (q0.size() == 0) || full0 !== (q0.size() == DEPTH) ||
                   af0 !== (q0.size() >= AF) || ae0 !== (q0.size() <= AE) || ovf0 !== m_ovf0 || unf0 !== m_unf0) begin
        n_fail++; $display("FAIL rnd_state0 cyc=%0d: got cnt=%0d ovf=%b unf=%b af=%b ae=%b want cnt=%0d ovf=%b unf=%b",
                           c, cnt0, ovf0, unf0, af0, ae0, q0.size(), m_ovf0, m_unf0); end
      if (q0.size() > 0) begin
        n_cmp++; if (dout0 !== q0[0]) begin
          n_fail++; $display("FAIL rnd_data0 cyc=%0d: got %h want %h", c, dout0, q0[0]); end
      end
      n_cmp++; if (cnt1 !== 5'(q1.size()) || empty1 !== (q1.size() == 0) || full1 !== (q1.size() == DEPTH) ||
                   af1 !== (q1.size() >= AF) || ae1 !== (q1.size() <= AE) || ovf1 !== m_ovf1 || unf1 !== m_unf1) begin
        n_fail++; $display("FAIL rnd_state1 cyc=%0d: got cnt=%0d ovf=%b unf=%b af=%b ae=%b want cnt=%0d ovf=%b unf=%b",
                           c, cnt1, ovf1, unf1, af1, ae1, q1.size(), m_ovf1, m_unf1); end
      if (q1.size() > 0) begin
        n_cmp++; if (dout1 !== q1[0]) begin
          n_fail++; $display("FAIL rnd_data1 cyc=%0d: got %h want %h", c, dout1, q1[0]); end
      end
      we0 = ($urandom_range(0, 99) < (((c / 100) % 2 == 0) ? 75 : 25));
      re0 = ($urandom_range(0, 99) < (((c / 100) % 2 == 0) ? 25 : 75));
      we1 = ($urandom_range(0, 99) < 60);
      re1 = ($urandom_range(0, 99) < 40);
      flush = ($urandom_range(0, 79) == 0);
      clear_err = ($urandom_range(0, 29) == 0);
      data_in = 8'($urandom);
      tick();
    end
    we0 = 0; re0 = 0; we1 = 0; re1 = 0; flush = 0; clear_err = 0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_passthrough();
    test_underflow();
    test_wrap();
    test_edge_mode();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
